// File: rtl/microphone_capture.sv
// -----------------------------------------------------------------------------
// microphone_capture
//
// Captures left-channel 16-bit PCM samples from an asynchronous I2S source,
// compresses each to 8-bit G.711 mu-law and packs four consecutive codes into
// one 32-bit word handed to the host through a valid/retrieved handshake.
// All logic runs on clk; the I2S lines are oversampled through synchronisers.
//
// Ports
//   clk                 in   system clock
//   rst_n               in   asynchronous active-low reset
//   record_start        in   one-cycle pulse, arms recording after START_DELAY
//   record_stop         in   one-cycle pulse, stops recording (wins over start)
//   bclk                in   I2S bit clock (asynchronous)
//   audio_data_in       in   I2S serial data
//   lrck                in   I2S word select, low = left channel
//   mic_data[31:0]      out  packed mu-law bytes, first sample in [31:24]
//   mic_data_valid      out  mic_data holds a complete word
//   mic_data_retrieved  in   one-cycle pulse, consumer has taken the word
//   mic_debug[1:0]      out  {mic_data_valid, record_active}
// -----------------------------------------------------------------------------
module microphone_capture #(
  parameter int START_DELAY = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        record_start,
  input  logic        record_stop,
  input  logic        bclk,
  input  logic        audio_data_in,
  input  logic        lrck,
  output logic [31:0] mic_data,
  output logic        mic_data_valid,
  input  logic        mic_data_retrieved,
  output logic [1:0]  mic_debug
);

  localparam int                 CNT_W     = $clog2(START_DELAY + 1);
  localparam logic [CNT_W-1:0]   START_CNT = CNT_W'(START_DELAY);

  typedef enum logic [1:0] {
    RX_IDLE,   // waiting for a left-channel frame edge
    RX_SHIFT,  // shifting in the 16 sample bits
    RX_EMIT    // next bclk rise releases the sample
  } rx_state_e;

  // ---------------------------------------------------------------------------
  // Input synchronisers and bclk edge detect
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrck_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   bclk_prev_q;
  logic                   bclk_s;
  logic                   lrck_s;
  logic                   data_s;
  logic                   bclk_rise;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      data_sync_q <= '0;
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], lrck};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], audio_data_in};
      bclk_prev_q <= bclk_sync_q[SYNC_STAGES-1];
    end
  end

  // lrck and data travel through the same depth as bclk, so they are sampled
  // with the same alignment they had at the pins.
  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
  assign data_s    = data_sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev_q;

  // ---------------------------------------------------------------------------
  // I2S receiver
  // ---------------------------------------------------------------------------
  rx_state_e   rx_state_q, rx_state_d;
  logic        lrck_prev_q, lrck_prev_d;
  logic [15:0] shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [12:0] sample_q, sample_d;     // only sample[15:3] feeds the encoder
  logic        sample_ready_q, sample_ready_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q     <= RX_IDLE;
      lrck_prev_q    <= 1'b0;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      sample_q       <= '0;
      sample_ready_q <= 1'b0;
    end else begin
      rx_state_q     <= rx_state_d;
      lrck_prev_q    <= lrck_prev_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      sample_q       <= sample_d;
      sample_ready_q <= sample_ready_d;
    end
  end

  // NOTE: every always_comb output gets a default first; a path that leaves a
  // signal unassigned would otherwise infer a latch.
  always_comb begin
    rx_state_d     = rx_state_q;
    lrck_prev_d    = lrck_prev_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    sample_d       = sample_q;
    sample_ready_d = 1'b0;

    if (bclk_rise) begin
      lrck_prev_d = lrck_s;
      if (lrck_prev_q && !lrck_s) begin
        // Left frame edge: the bit on this edge is the I2S delay bit.
        shift_d    = '0;
        bit_cnt_d  = '0;
        rx_state_d = RX_SHIFT;
      end else begin
        case (rx_state_q)
          RX_SHIFT: begin
            shift_d   = {shift_q[14:0], data_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) rx_state_d = RX_EMIT;
          end
          RX_EMIT: begin
            sample_d       = shift_q[15:3];
            sample_ready_d = 1'b1;
            rx_state_d     = RX_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // mu-law encoder
  // mag = min(2|x|, 8158) + 33 is always odd, so the encoder works on
  // mag >> 1 = min(|x|, 4079) + 16; the leading-one search then covers bits
  // 11..4 instead of 12..5 and the mantissa is the four bits below it.
  // ---------------------------------------------------------------------------
  logic        ulaw_sign;
  logic [12:0] ulaw_abs;
  logic [11:0] ulaw_half;
  logic [2:0]  ulaw_exp;
  logic [3:0]  ulaw_mant;
  logic [7:0]  ulaw_code;

  always_comb begin
    ulaw_sign = sample_q[12];
    // -4096 negates to 13'h1000, which is correct when read as unsigned.
    ulaw_abs  = ulaw_sign ? (13'd0 - sample_q) : sample_q;
    ulaw_half = ((ulaw_abs > 13'd4079) ? 12'd4079 : ulaw_abs[11:0]) + 12'd16;
    ulaw_exp  = '0;
    ulaw_mant = '0;
    for (int i = 4; i <= 11; i++) begin
      if (ulaw_half[i]) begin
        ulaw_exp  = 3'(i - 4);
        ulaw_mant = ulaw_half[i-1 -: 4];
      end
    end
    ulaw_code = ~{ulaw_sign, ulaw_exp, ulaw_mant};
  end

  // ---------------------------------------------------------------------------
  // Record control and word packing
  // ---------------------------------------------------------------------------
  logic             active_q, active_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] delay_cnt_q, delay_cnt_d;
  logic [31:0]      mic_data_q, mic_data_d;
  logic             filled_q, filled_d;
  logic [1:0]       byte_idx_q, byte_idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= 1'b0;
      armed_q     <= 1'b0;
      delay_cnt_q <= '0;
      mic_data_q  <= '0;
      filled_q    <= 1'b0;
      byte_idx_q  <= '0;
    end else begin
      active_q    <= active_d;
      armed_q     <= armed_d;
      delay_cnt_q <= delay_cnt_d;
      mic_data_q  <= mic_data_d;
      filled_q    <= filled_d;
      byte_idx_q  <= byte_idx_d;
    end
  end

  always_comb begin
    active_d    = active_q;
    armed_d     = armed_q;
    delay_cnt_d = delay_cnt_q;

    if (record_stop) begin
      active_d = 1'b0;
      armed_d  = 1'b0;
    end else if (record_start) begin
      armed_d     = 1'b1;
      delay_cnt_d = '0;
    end else if (armed_q) begin
      if (delay_cnt_q == START_CNT) begin
        active_d = 1'b1;
        armed_d  = 1'b0;
      end else begin
        delay_cnt_d = delay_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    mic_data_d = mic_data_q;
    filled_d   = filled_q;
    byte_idx_d = byte_idx_q;

    if (!active_q && active_d) begin
      // Recording just became active: present a full word of silence.
      mic_data_d = 32'hFFFF_FFFF;
      filled_d   = 1'b1;
      byte_idx_d = '0;
    end else if (filled_q) begin
      // A full word blocks packing; incoming samples are dropped.
      if (mic_data_retrieved) filled_d = 1'b0;
    end else if (active_q && sample_ready_q && !mic_data_retrieved) begin
      case (byte_idx_q)
        2'd0:    mic_data_d[31:24] = ulaw_code;
        2'd1:    mic_data_d[23:16] = ulaw_code;
        2'd2:    mic_data_d[15:8]  = ulaw_code;
        default: mic_data_d[7:0]   = ulaw_code;
      endcase
      byte_idx_d = byte_idx_q + 2'd1;
      if (byte_idx_q == 2'd3) filled_d = 1'b1;
    end
  end

  assign mic_data       = mic_data_q;
  assign mic_data_valid = active_q & filled_q;
  assign mic_debug      = {mic_data_valid, active_q};

endmodule

// File: tb/tb_microphone_capture.sv
// -----------------------------------------------------------------------------
// tb_microphone_capture
//
// Self-checking bench for microphone_capture. Drives I2S frames at clk/10,
// checks table vectors and randomised samples against an arithmetic mu-law
// model, and exercises start delay, retrieve, stop/start and reset corners.
// -----------------------------------------------------------------------------
module tb_microphone_capture;

  logic        clk;
  logic        rst_n;
  logic        record_start;
  logic        record_stop;
  logic        bclk;
  logic        audio_data_in;
  logic        lrck;
  logic [31:0] mic_data;
  logic        mic_data_valid;
  logic        mic_data_retrieved;
  logic [1:0]  mic_debug;

  microphone_capture #(
    .START_DELAY (10),
    .SYNC_STAGES (2)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .record_start       (record_start),
    .record_stop        (record_stop),
    .bclk               (bclk),
    .audio_data_in      (audio_data_in),
    .lrck               (lrck),
    .mic_data           (mic_data),
    .mic_data_valid     (mic_data_valid),
    .mic_data_retrieved (mic_data_retrieved),
    .mic_debug          (mic_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected packed word and next byte slot, maintained at transaction level.
  logic [31:0] exp_word;
  int          exp_idx;

  typedef struct {
    logic [15:0] sample;
    logic [7:0]  code;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // G.711 mu-law from the arithmetic definition.
  function automatic logic [7:0] ulaw_ref(input logic [15:0] s);
    int x, mag, e, m, sgn, code;
    x   = int'($signed(s)) >>> 3;
    sgn = (x < 0) ? 1 : 0;
    mag = ((x < 0) ? -x : x) * 2;
    if (mag > 8158) mag = 8158;
    mag = mag + 33;
    e = 0;
    while (mag >= (64 << e)) e++;
    m    = (mag >> (e + 1)) & 15;
    code = (sgn << 7) | (e << 4) | m;
    return ~8'(code);
  endfunction

  // One bclk period: fall with new lrck/data, 5 clk low, rise, 5 clk high.
  task automatic i2s_bit(input logic lr, input logic d);
    bclk          = 1'b0;
    lrck          = lr;
    audio_data_in = d;
    repeat (5) @(negedge clk);
    bclk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // Right half (random data) followed by left half carrying s MSB-first
  // after the delay bit.
  task automatic send_frame(input logic [15:0] s);
    for (int k = 0; k < 20; k++) i2s_bit(1'b1, 1'($urandom));
    for (int k = 0; k < 20; k++) begin
      if (k >= 1 && k <= 16) i2s_bit(1'b0, s[16-k]);
      else                   i2s_bit(1'b0, 1'($urandom));
    end
  endtask

  task automatic push_accepted(input logic [15:0] s, input logic [7:0] code, input string name);
    send_frame(s);
    exp_word[8*(3-exp_idx) +: 8] = code;
    exp_idx = (exp_idx + 1) % 4;
    check({name, " word"}, mic_data, exp_word);
    check({name, " valid"}, 32'(mic_data_valid), 32'(exp_idx == 0));
  endtask

  task automatic push_dropped(input string name);
    send_frame(16'($urandom));
    check({name, " word held"}, mic_data, exp_word);
    check({name, " valid held"}, 32'(mic_data_valid), 32'd1);
  endtask

  task automatic do_retrieve(input string name);
    mic_data_retrieved = 1'b1;
    @(negedge clk);
    mic_data_retrieved = 1'b0;
    check({name, " valid after retrieve"}, 32'(mic_data_valid), 32'd0);
  endtask

  task automatic do_stop(input string name);
    record_stop = 1'b1;
    @(negedge clk);
    record_stop = 1'b0;
    check({name, " debug after stop"}, 32'(mic_debug), 32'd0);
  endtask

  // Start pulse sampled at edge E0; record_active must rise exactly at E11.
  task automatic start_and_wait(input string name);
    record_start = 1'b1;
    @(negedge clk);
    record_start = 1'b0;
    repeat (10) @(negedge clk);
    check({name, " active early"}, 32'(mic_debug[0]), 32'd0);
    @(negedge clk);
    check({name, " active on time"}, 32'(mic_debug[0]), 32'd1);
    exp_word = 32'hFFFF_FFFF;
    exp_idx  = 0;
    check({name, " seeded word"}, mic_data, exp_word);
    check({name, " seeded debug"}, 32'(mic_debug), 32'd3);
  endtask

  initial begin
    logic [15:0] rs;
    int          ndrop;

    vecs[0]  = '{16'h5A5A, 8'h89};
    vecs[1]  = '{16'hA5A5, 8'h09};
    vecs[2]  = '{16'h0001, 8'hFF};
    vecs[3]  = '{16'hFFFF, 8'h7E};
    vecs[4]  = '{16'h0000, 8'hFF};  // x = 0
    vecs[5]  = '{16'hFFF8, 8'h7E};  // x = -1
    vecs[6]  = '{16'h7FF8, 8'h80};  // x = 4095
    vecs[7]  = '{16'h8000, 8'h00};  // x = -4096
    vecs[8]  = '{16'h0008, 8'hFE};  // x = 1
    vecs[9]  = '{16'h0010, 8'hFD};  // x = 2
    vecs[10] = '{16'hFFF0, 8'h7D};  // x = -2
    vecs[11] = '{16'h0400, 8'hCD};  // x = 128

    rst_n              = 1'b0;
    record_start       = 1'b0;
    record_stop        = 1'b0;
    mic_data_retrieved = 1'b0;
    bclk               = 1'b0;
    lrck               = 1'b1;
    audio_data_in      = 1'b0;
    exp_word           = '0;
    exp_idx            = 0;

    repeat (3) @(negedge clk);
    check("reset mic_data", mic_data, 32'd0);
    check("reset valid", 32'(mic_data_valid), 32'd0);
    check("reset debug", 32'(mic_debug), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Start, seeded silence word, retrieve.
    start_and_wait("start1");
    do_retrieve("seed");

    // Table vectors; after the first word, two frames arrive unretrieved.
    for (int i = 0; i < 12; i++) begin
      push_accepted(vecs[i].sample, vecs[i].code, $sformatf("vec%0d", i));
      if (exp_idx == 0) begin
        if (i == 3) begin
          check("test plan word", mic_data, 32'h8909_FF7E);
          push_dropped("withhold1");
          push_dropped("withhold2");
        end
        do_retrieve($sformatf("vec%0d", i));
      end
    end

    // Randomised samples against the reference encoder.
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < 4; j++) begin
        rs = 16'($urandom);
        push_accepted(rs, ulaw_ref(rs), $sformatf("rand w%0d s%0d", w, j));
      end
      ndrop = $urandom_range(1, 0);
      for (int d = 0; d < ndrop; d++) push_dropped($sformatf("rand drop w%0d", w));
      do_retrieve($sformatf("rand w%0d", w));
    end

    // Stop mid-word, then simultaneous start+stop keeps recording off.
    push_accepted(16'h0000, 8'hFF, "midword");
    do_stop("midword");
    record_start = 1'b1;
    record_stop  = 1'b1;
    @(negedge clk);
    record_start = 1'b0;
    record_stop  = 1'b0;
    repeat (15) @(negedge clk);
    check("start+stop stays inactive", 32'(mic_debug[0]), 32'd0);

    // Restart reseeds, stop while valid, restart again, then index is 0.
    start_and_wait("restart1");
    do_stop("stop valid");
    check("stop valid low", 32'(mic_data_valid), 32'd0);
    start_and_wait("restart2");
    do_retrieve("restart2");
    push_accepted(16'h5A5A, 8'h89, "after restart");

    // Reset in the middle of a left-channel frame.
    for (int k = 0; k < 20; k++) i2s_bit(1'b1, 1'($urandom));
    for (int k = 0; k < 8; k++)  i2s_bit(1'b0, 1'($urandom));
    rst_n = 1'b0;
    #1;
    check("midframe reset mic_data", mic_data, 32'd0);
    check("midframe reset valid", 32'(mic_data_valid), 32'd0);
    check("midframe reset debug", 32'(mic_debug), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_and_wait("post reset");
    do_retrieve("post reset");
    push_accepted(16'hA5A5, 8'h09, "post reset frame");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
